// File: rtl/dwbus_mailbox.sv
// Byte mailbox on the CPU data bus: CPU-to-consumer TX FIFO and producer-to-CPU RX FIFO.
// Optional MAILBOX_IRQ_EN adds the oIRQ output and stored interrupt-enable bits in CONTROL.
module dwbus_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_W     = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oHit,
  output logic        oTxValid,
  output logic [7:0]  oTxData,
  input  logic        iTxReady,
  input  logic        iRxValid,
  input  logic [7:0]  iRxData,
`ifdef MAILBOX_IRQ_EN
  output logic        oRxReady,
  output logic        oIRQ
`else
  output logic        oRxReady
`endif
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       txMem [DEPTH];
  logic [7:0]       rxMem [DEPTH];
  logic [PTR_W-1:0] txWr, txRd, rxWr, rxRd;
  logic [CNT_W-1:0] txCount, rxCount;
  logic             txOvfFlag, rxUndFlag;
  logic [1:0]       offset;
  logic             txFull, txEmpty, rxFull, rxEmpty;
  logic             ctrlWr, clearSticky, flushTx, flushRx;
  logic             txPushReq, txPush, txPop, txOvf;
  logic             rxReadReq, rxPop, rxUnd, rxPush;
  logic [31:0]      status;
  logic             unusedBits;

  assign unusedBits = ^{iAddress[1:0], iWriteData[31:3], iByteEnable[3:1]};

  // Address decode and bus-side events
  assign oHit    = (iAddress[31:4] == BASE_ADDR[31:4]);
  assign offset  = iAddress[3:2];
  assign txFull  = (txCount == CNT_W'(DEPTH));
  assign txEmpty = (txCount == '0);
  assign rxFull  = (rxCount == CNT_W'(DEPTH));
  assign rxEmpty = (rxCount == '0);

  assign ctrlWr      = oHit && iWriteEnable && iByteEnable[0] && (offset == 2'd3);
  assign clearSticky = ctrlWr && iWriteData[0];
  assign flushTx     = ctrlWr && iWriteData[1];
  assign flushRx     = ctrlWr && iWriteData[2];

  // Flush takes priority over any push on the same FIFO and suppresses the overflow flag
  assign txPushReq = oHit && iWriteEnable && iByteEnable[0] && (offset == 2'd0);
  assign txPush    = txPushReq && !txFull && !flushTx;
  assign txOvf     = txPushReq && txFull && !flushTx;
  assign txPop     = !txEmpty && iTxReady;

  assign rxReadReq = oHit && iReadEnable && (offset == 2'd1);
  assign rxPop     = rxReadReq && !rxEmpty;
  assign rxUnd     = rxReadReq && rxEmpty;
  assign rxPush    = iRxValid && !rxFull && !flushRx;

  assign oTxValid = !txEmpty;
  assign oTxData  = txMem[txRd];
  assign oRxReady = !rxFull;

  always_ff @(posedge iCLK) begin
    if (txPush) txMem[txWr] <= iWriteData[7:0];
    if (rxPush) rxMem[rxWr] <= iRxData;
  end

  // TX pointers and count
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      txWr    <= '0;
      txRd    <= '0;
      txCount <= '0;
    end else if (flushTx) begin
      txWr    <= '0;
      txRd    <= '0;
      txCount <= '0;
    end else begin
      if (txPush) txWr <= txWr + PTR_W'(1);
      if (txPop)  txRd <= txRd + PTR_W'(1);
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + CNT_W'(1);
        2'b01:   txCount <= txCount - CNT_W'(1);
        default: txCount <= txCount;
      endcase
    end
  end

  // RX pointers and count
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rxWr    <= '0;
      rxRd    <= '0;
      rxCount <= '0;
    end else if (flushRx) begin
      rxWr    <= '0;
      rxRd    <= '0;
      rxCount <= '0;
    end else begin
      if (rxPush) rxWr <= rxWr + PTR_W'(1);
      if (rxPop)  rxRd <= rxRd + PTR_W'(1);
      case ({rxPush, rxPop})
        2'b10:   rxCount <= rxCount + CNT_W'(1);
        2'b01:   rxCount <= rxCount - CNT_W'(1);
        default: rxCount <= rxCount;
      endcase
    end
  end

  // Sticky flags: a new event in the clearing cycle wins
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      txOvfFlag <= 1'b0;
      rxUndFlag <= 1'b0;
    end else begin
      txOvfFlag <= (txOvfFlag && !clearSticky) || txOvf;
      rxUndFlag <= (rxUndFlag && !clearSticky) || rxUnd;
    end
  end

`ifdef MAILBOX_IRQ_EN
  logic irqRxEn, irqTxEn;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      irqRxEn <= 1'b0;
      irqTxEn <= 1'b0;
      oIRQ    <= 1'b0;
    end else begin
      if (ctrlWr) begin
        irqRxEn <= iWriteData[3];
        irqTxEn <= iWriteData[4];
      end
      oIRQ <= (irqRxEn && !rxEmpty) || (irqTxEn && txEmpty);
    end
  end
`endif

  always_comb begin
    status        = '0;
    status[0]     = txFull;
    status[1]     = txEmpty;
    status[2]     = rxFull;
    status[3]     = rxEmpty;
    status[4]     = txOvfFlag;
    status[5]     = rxUndFlag;
    status[15:8]  = 8'(txCount);
    status[23:16] = 8'(rxCount);
`ifdef MAILBOX_IRQ_EN
    status[25:24] = {irqTxEn, irqRxEn};
`endif
  end

  always_comb begin
    oReadData = '0;
    if (oHit) begin
      case (offset)
        2'd1:    oReadData = rxEmpty ? 32'h0 : {24'h0, rxMem[rxRd]};
        2'd2:    oReadData = status;
        default: oReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dwbus_mailbox.sv
// Scoreboard bench for dwbus_mailbox: bus reads and TX bytes are checked by a monitor against queued expectations.
// Define MAILBOX_IRQ_EN to include the interrupt checks.
module tb_dwbus_mailbox;

  localparam logic [31:0] BASE = 32'hFF20_0000;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iReadEnable, iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress, iWriteData, oReadData;
  logic        oHit, oTxValid, iTxReady, iRxValid, oRxReady;
  logic [7:0]  oTxData, iRxData;
`ifdef MAILBOX_IRQ_EN
  logic        oIRQ;
`endif

  int nChecks = 0;
  int nPass   = 0;
  logic [31:0] readQ[$];
  logic [7:0]  txQ[$];

  dwbus_mailbox dut (
    .iCLK(iCLK), .iRST(iRST),
    .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
    .iByteEnable(iByteEnable), .iAddress(iAddress), .iWriteData(iWriteData),
    .oReadData(oReadData), .oHit(oHit),
    .oTxValid(oTxValid), .oTxData(oTxData), .iTxReady(iTxReady),
    .iRxValid(iRxValid), .iRxData(iRxData),
`ifdef MAILBOX_IRQ_EN
    .oRxReady(oRxReady), .oIRQ(oIRQ)
`else
    .oRxReady(oRxReady)
`endif
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: compares every presented read and every accepted TX byte
  always @(negedge iCLK) begin
    if (iRST === 1'b0) begin
      if (iReadEnable && oHit) begin
        if (readQ.size() == 0) begin
          nChecks++;
          $display("FAIL rd_unexpected: got %h required no read", oReadData);
        end else chk("rd", oReadData, readQ.pop_front());
      end
      if (oTxValid && iTxReady) begin
        if (txQ.size() == 0) begin
          nChecks++;
          $display("FAIL tx_unexpected: got %h required no byte", oTxData);
        end else chk("tx", 32'(oTxData), 32'(txQ.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] off, input logic [31:0] data);
    iAddress = BASE + off; iWriteData = data; iByteEnable = 4'b0001; iWriteEnable = 1'b1;
    tick();
    iWriteEnable = 1'b0; iByteEnable = 4'b0000; iAddress = 32'h0;
  endtask

  task automatic busRead(input logic [31:0] off, input logic [31:0] exp);
    readQ.push_back(exp);
    iAddress = BASE + off; iReadEnable = 1'b1;
    tick();
    iReadEnable = 1'b0; iAddress = 32'h0;
  endtask

  initial begin
    iRST = 1'b1; iReadEnable = 0; iWriteEnable = 0; iByteEnable = 0;
    iAddress = 0; iWriteData = 0; iTxReady = 0; iRxValid = 0; iRxData = 0;
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;

    // Reset state
    busRead(32'h8, 32'h0000_000A);
    chk("rst_txvalid", 32'(oTxValid), 32'd0);
    chk("rst_rxready", 32'(oRxReady), 32'd1);
`ifdef MAILBOX_IRQ_EN
    chk("rst_irq", 32'(oIRQ), 32'd0);
`endif

    // Two stored bytes, then drained in order
    busWrite(32'h0, 32'h0000_0041);
    busWrite(32'h0, 32'hFFFF_FF42);
    busRead(32'h8, 32'h0000_0208);
    txQ.push_back(8'h41); txQ.push_back(8'h42);
    iTxReady = 1'b1;
    repeat (3) tick();
    chk("tx_drained", 32'(oTxValid), 32'd0);
    iTxReady = 1'b0;

    // Overflow on 17th store; low address bits ignored
    for (int i = 0; i < 17; i++) busWrite(32'h0, 32'(8'h60 + i));
    busRead(32'h9, 32'h0000_1019);
    busWrite(32'hC, 32'h1);
    busRead(32'h8, 32'h0000_1009);
    // Full FIFO, push and consumer pop in the same cycle: push rejected
    txQ.push_back(8'h60);
    iTxReady = 1'b1;
    busWrite(32'h0, 32'h99);
    iTxReady = 1'b0;
    busRead(32'h8, 32'h0000_0F18);
    for (int i = 1; i < 16; i++) txQ.push_back(8'(8'h60 + i));
    iTxReady = 1'b1;
    repeat (15) tick();
    chk("tx_17th_dropped", 32'(oTxValid), 32'd0);
    iTxReady = 1'b0;
    busWrite(32'h0, 32'h01);
    busWrite(32'h0, 32'h02);
    busWrite(32'hC, 32'h2);
    busRead(32'h8, 32'h0000_001A);
    busWrite(32'hC, 32'h1);
    busRead(32'h8, 32'h0000_000A);
    busRead(32'h0, 32'h0);
    busRead(32'hC, 32'h0);

    // Address outside the window
    iAddress = BASE + 32'h10; iReadEnable = 1'b1;
    #1;
    chk("nohit_hit", 32'(oHit), 32'd0);
    chk("nohit_data", oReadData, 32'h0);
    tick();
    iReadEnable = 1'b0; iAddress = 32'h0;

    // Producer fills two bytes; third read underflows
    iRxValid = 1'b1; iRxData = 8'h55; tick();
    iRxData = 8'h66; tick();
    iRxValid = 1'b0;
    busRead(32'h4, 32'h55);
    busRead(32'h4, 32'h66);
    busRead(32'h4, 32'h0);
    busRead(32'h8, 32'h0000_002A);

    // Read of empty RX coincides with a producer push
    busWrite(32'hC, 32'h1);
    iRxValid = 1'b1; iRxData = 8'h77;
    busRead(32'h4, 32'h0);
    iRxValid = 1'b0;
    busRead(32'h8, 32'h0001_0022);
    busRead(32'h4, 32'h77);
    busRead(32'h8, 32'h0000_002A);

    // RX full backpressure, then flush beats a same-cycle push
    busWrite(32'hC, 32'h1);
    iRxValid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      iRxData = 8'(8'hA0 + i);
      tick();
    end
    iRxValid = 1'b0;
    chk("rx_full_ready", 32'(oRxReady), 32'd0);
    busRead(32'h8, 32'h0010_0006);
    busRead(32'h4, 32'hA0);
    iRxValid = 1'b1; iRxData = 8'h33;
    busWrite(32'hC, 32'h4);
    iRxValid = 1'b0;
    busRead(32'h8, 32'h0000_000A);

`ifdef MAILBOX_IRQ_EN
    busWrite(32'hC, 32'h8);
    busRead(32'h8, 32'h0100_000A);
    iRxValid = 1'b1; iRxData = 8'h10; tick();
    iRxValid = 1'b0;
    chk("irq_push_edge", 32'(oIRQ), 32'd0);
    tick();
    chk("irq_set", 32'(oIRQ), 32'd1);
    busRead(32'h4, 32'h10);
    chk("irq_pop_edge", 32'(oIRQ), 32'd1);
    tick();
    chk("irq_clr", 32'(oIRQ), 32'd0);
    iRxValid = 1'b1; iRxData = 8'h11; tick();
    iRxValid = 1'b0;
    tick();
    chk("irq_set2", 32'(oIRQ), 32'd1);
    @(negedge iCLK);
    #2 iRST = 1'b1;
    #1;
    chk("irq_async_rst", 32'(oIRQ), 32'd0);
    tick();
    iRST = 1'b0;
`endif

    repeat (3) tick();
    chk("readq_empty", 32'(readQ.size()), 32'd0);
    chk("txq_empty", 32'(txQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
